// File: rtl/bdc_target_responder.sv
// BDC target-side responder on the single-wire BKGD line.
// Decodes host low pulses into bits, drives zero bits for a queued transmit
// byte, and answers a host SYNC with the 128-tick target low pulse.
// BKGD is only ever pulled low (open-drain); release means high-Z.
module bdc_target_responder #(
  parameter int BDC_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bkgd_in,
  output logic       bkgd_out,
  output logic       bkgd_is_high_z,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sync_seen,
  output logic [3:0] debug
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOW        = 3'd1,
    SYNC_WAIT  = 3'd2,
    SYNC_DRIVE = 3'd3,
    WAIT_HIGH  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SAMP_T  = CNT_W'(10 * BDC_DIV);
  localparam logic [CNT_W-1:0] ZERO_T  = CNT_W'(13 * BDC_DIV);
  localparam logic [CNT_W-1:0] WAIT_T  = CNT_W'(16 * BDC_DIV);
  localparam logic [CNT_W-1:0] SYNC_T  = CNT_W'(128 * BDC_DIV);
  localparam logic [CNT_W-1:0] DRV_END = CNT_W'(128 * BDC_DIV - 1);

  state_t           state, state_d;
  logic             s1, s2, prev;
  logic             fall, rise;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift, tx_shift;
  logic             samp;
  logic             bit_val;
  logic             accept, commit, sync_hit, do_sample, start_low;
  logic             zero_win;

  assign fall     = ~s2 & prev;
  assign rise     = s2 & ~prev;
  assign bkgd_out = 1'b0;
  assign debug    = {1'b0, state};

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= bkgd_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state, counter control and BKGD drive decode.
  always_comb begin
    state_d   = state;
    cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    cnt_d     = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    sync_hit  = 1'b0;
    do_sample = 1'b0;
    start_low = 1'b0;
    // A rise landing exactly on the sample point sees the line high.
    bit_val   = (cnt == SAMP_T) ? s2 : samp;
    // Pulse length is judged on the count including the rise cycle.
    zero_win  = (state == LOW) && tx_busy && !tx_shift[7] && (cnt < ZERO_T);
    case (state)
      IDLE: begin
        if (fall) begin
          state_d   = LOW;
          cnt_d     = '0;
          start_low = 1'b1;
        end else if (tx_load && (bit_cnt == 3'd0) && !tx_busy) begin
          accept = 1'b1;
        end
      end
      LOW: begin
        cnt_d = cnt_inc;
        if (cnt == SAMP_T) do_sample = 1'b1;
        if (rise) begin
          if (cnt_inc >= SYNC_T) begin
            sync_hit = 1'b1;
            state_d  = SYNC_WAIT;
            cnt_d    = '0;
          end else begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      SYNC_WAIT: begin
        // The sync_seen cycle is the first wait cycle; 16 ticks more follow.
        cnt_d = cnt_inc;
        if (cnt == WAIT_T) begin
          state_d = SYNC_DRIVE;
          cnt_d   = '0;
        end
      end
      SYNC_DRIVE: begin
        cnt_d = cnt_inc;
        if (cnt == DRV_END) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (s2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bkgd_is_high_z = !(zero_win || (state == SYNC_DRIVE));
  end

  // Datapath: shift registers, bit counter, strobes and transmit arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      tx_busy   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      sync_seen <= 1'b0;
      samp      <= 1'b1;
    end else begin
      cnt       <= cnt_d;
      rx_valid  <= 1'b0;
      sync_seen <= sync_hit;
      if (start_low)      samp <= 1'b1;
      else if (do_sample) samp <= s2;
      if (accept) begin
        tx_shift <= tx_data;
        tx_busy  <= 1'b1;
      end
      if (commit) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (tx_busy) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          if (bit_cnt == 3'd7) tx_busy <= 1'b0;
        end else begin
          rx_shift <= {rx_shift[6:0], bit_val};
          if (bit_cnt == 3'd7) begin
            rx_data  <= {rx_shift[6:0], bit_val};
            rx_valid <= 1'b1;
          end
        end
      end
      if (sync_hit) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        tx_busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bdc_target_responder.sv
// Bench for bdc_target_responder: host pulses on a wired-AND BKGD line,
// expected bytes and drive-window lengths queued ahead of the traffic and
// consumed by a monitor as the responder produces them.
module tb_bdc_target_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_low = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       bkgd_in;
  logic       bkgd_out, bkgd_is_high_z, tx_busy, rx_valid, sync_seen;
  logic [7:0] rx_data;
  logic [3:0] debug;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int run = 0;
  int rx_cnt = 0;
  int sync_cnt = 0;
  int sync_cyc = 0;
  int drv_start = 0;
  logic [7:0] exp_rx[$];
  int         exp_drv[$];

  // Open-drain line: low if host pulls or target drives.
  assign bkgd_in = !host_low && (bkgd_is_high_z ? 1'b1 : bkgd_out);

  bdc_target_responder #(.BDC_DIV(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bkgd_in(bkgd_in), .bkgd_out(bkgd_out),
    .bkgd_is_high_z(bkgd_is_high_z), .tx_data(tx_data), .tx_load(tx_load),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .sync_seen(sync_seen), .debug(debug)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_pulse(input int low, input int gap);
    host_low = 1'b1;
    tick(low);
    host_low = 1'b0;
    tick(gap);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) host_pulse(b[i] ? 16 : 52, gap);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (debug != 4'd0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, debug, 4'd0);
  endtask

  task automatic load(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: consumes expected bytes and drive-window lengths.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      run = 0;
    end else begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) chk("rx_unexpected", exp_rx.size(), 1);
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (sync_seen) begin
        sync_cnt++;
        sync_cyc = cyc;
      end
      if (!bkgd_is_high_z) begin
        if (run == 0) drv_start = cyc;
        run++;
      end else if (run > 0) begin
        if (exp_drv.size() == 0) chk("drv_unexpected", exp_drv.size(), 1);
        else chk("drv_len", run, exp_drv.pop_front());
        run = 0;
      end
    end
  end

  initial begin
    int s0, r0, n;
    // Reset state
    tick(3);
    chk("rst_high_z", bkgd_is_high_z, 1);
    chk("rst_bkgd_out", bkgd_out, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_sync_seen", sync_seen, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_debug", debug, 0);
    rst_n = 1'b1;
    tick(5);

    // Host SYNC: 600-clock low
    s0 = sync_cnt;
    exp_drv.push_back(512);
    host_pulse(600, 0);
    wait_idle("sync_idle", 1000);
    chk("sync_once", sync_cnt - s0, 1);
    chk("sync_gap", drv_start - sync_cyc, 65);
    chk("sync_drv_done", exp_drv.size(), 0);
    tick(10);

    // Receive 0xA5
    r0 = rx_cnt;
    exp_rx.push_back(8'hA5);
    send_byte(8'hA5, 40);
    tick(5);
    chk("rx_a5_count", rx_cnt - r0, 1);
    chk("rx_a5_data", rx_data, 8'hA5);
    chk("rx_a5_busy", tx_busy, 0);

    // Transmit 0x3C
    r0 = rx_cnt;
    load(8'h3C);
    chk("tx_busy_set", tx_busy, 1);
    repeat (4) exp_drv.push_back(52);
    for (int i = 0; i < 7; i++) host_pulse(16, 80);
    chk("tx_busy_7", tx_busy, 1);
    host_pulse(16, 80);
    chk("tx_busy_8", tx_busy, 0);
    chk("tx_drv_done", exp_drv.size(), 0);
    chk("tx_no_rx", rx_cnt - r0, 0);

    // Armed 0x00 aborted by SYNC after 3 bits
    load(8'h00);
    chk("abort_busy_set", tx_busy, 1);
    repeat (4) exp_drv.push_back(52);
    exp_drv.push_back(512);
    for (int i = 0; i < 3; i++) host_pulse(16, 80);
    s0 = sync_cnt;
    host_pulse(600, 0);
    n = 0;
    while (sync_cnt == s0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("abort_sync", sync_cnt - s0, 1);
    chk("abort_busy_clr", tx_busy, 0);
    wait_idle("abort_idle", 1000);
    chk("abort_drv_done", exp_drv.size(), 0);
    tick(5);
    load(8'hFF);
    chk("reload_busy", tx_busy, 1);
    for (int i = 0; i < 7; i++) host_pulse(16, 80);
    chk("reload_busy_7", tx_busy, 1);
    host_pulse(16, 80);
    chk("reload_busy_8", tx_busy, 0);

    // Boundary: 511 is a zero data bit, 512 is SYNC
    s0 = sync_cnt;
    exp_rx.push_back(8'h55);
    host_pulse(511, 40);
    chk("b511_no_sync", sync_cnt - s0, 0);
    chk("b511_idle", debug, 0);
    send_byte(8'hAA, 40); // low seven bits complete 0x55
    exp_drv.push_back(512);
    host_pulse(512, 0);
    wait_idle("b512_idle", 1000);
    chk("b512_sync", sync_cnt - s0, 1);
    chk("b_rx_done", exp_rx.size(), 0);
    chk("b_drv_done", exp_drv.size(), 0);

    // Reset in SYNC_DRIVE
    host_pulse(600, 0);
    n = 0;
    while (bkgd_is_high_z && n < 300) begin
      tick(1);
      n++;
    end
    chk("rd_drive_seen", bkgd_is_high_z, 0);
    tick(100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_high_z", bkgd_is_high_z, 1);
    chk("rd_rx_valid", rx_valid, 0);
    chk("rd_sync_seen", sync_seen, 0);
    chk("rd_debug", debug, 0);
    chk("rd_tx_busy", tx_busy, 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("end_high_z", bkgd_is_high_z, 1);
    chk("end_rx_q", exp_rx.size(), 0);
    chk("end_drv_q", exp_drv.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
